// File: rtl/ahb_master_arbiter_if.sv
// Requester-side and ahb_lite-side signals of the master arbiter.
// The arbiter connects through the master modport; the environment
// (requesters plus ahb_lite) uses the slave modport.
interface ahb_master_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    // requester command side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;

    // requester response side
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    // ahb_lite master port
    logic                      hbusreq;
    logic [ADDR_W-1:0]         haddr;
    logic                      haddr_ctrl;
    logic                      hwrite;
    logic [DATA_W-1:0]         hwdata;
    logic                      hgrant;
    logic                      hready_s2m;
    logic                      hresp_s2m;
    logic [DATA_W-1:0]         hdata_s2m;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  hgrant, hready_s2m, hresp_s2m, hdata_s2m,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output hbusreq, haddr, haddr_ctrl, hwrite, hwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output hgrant, hready_s2m, hresp_s2m, hdata_s2m,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  hbusreq, haddr, haddr_ctrl, hwrite, hwdata
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Shares the single ahb_lite master port between NUM_REQ requesters.
// One transfer in flight: IDLE -> REQ -> ADDR -> DATA -> RESP -> IDLE.
// Arbitration is round-robin (PRIO_MODE=0) or fixed, lowest index first
// (PRIO_MODE=1). REQ and DATA are guarded by a TIMEOUT-cycle abort.
module ahb_master_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input logic                  clk,
    input logic                  rst,
    ahb_master_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0]      TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [IDX_W:0]   NUM_REQ_W   = (IDX_W+1)'(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     owner;
    logic [15:0]          timer;
    logic [DATA_W-1:0]    rdata_r;
    logic                 err_r;

    // registered outputs
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;
    logic                 rsp_err_q;
    logic                 hbusreq_q;
    logic [ADDR_W-1:0]    haddr_q;
    logic                 haddr_ctrl_q;
    logic                 hwrite_q;
    logic [DATA_W-1:0]    hwdata_q;

    // arbitration results
    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [NUM_REQ-1:0]   rot_valid;
    logic [IDX_W-1:0]     rr_off;
    logic [IDX_W:0]       rr_sum;
    logic [IDX_W:0]       ptr_sum;
    logic [IDX_W-1:0]     winner;
    logic                 win_found;
    logic [IDX_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   req_ready_c;
    logic [NUM_REQ-1:0]   owner_onehot;

    // winner's command
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_write;

    // Rotating the request vector by the pointer turns round-robin into
    // a lowest-index search; the offset is added back modulo NUM_REQ.
    assign dbl_valid = {bus.req_valid, bus.req_valid};
    assign rot_valid = NUM_REQ'(dbl_valid >> rr_ptr);

    // Pick the winner among the currently valid requesters.
    always_comb begin
        rr_off    = '0;
        rr_sum    = '0;
        winner    = '0;
        win_found = 1'b0;
        if (PRIO_MODE != 0) begin
            // descending scan: the last hit is the lowest valid index
            for (int unsigned i = NUM_REQ; i > 0; i--) begin
                if (bus.req_valid[i-1]) begin
                    winner    = IDX_W'(i-1);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = NUM_REQ; i > 0; i--) begin
                if (rot_valid[i-1]) begin
                    rr_off    = IDX_W'(i-1);
                    win_found = 1'b1;
                end
            end
            rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
            if (rr_sum >= NUM_REQ_W) begin
                rr_sum = rr_sum - NUM_REQ_W;
            end
            winner = rr_sum[IDX_W-1:0];
        end
    end

    // Pointer advances to the requester after the winner, wrapping.
    always_comb begin
        ptr_sum = {1'b0, winner} + (IDX_W+1)'(1);
        if (ptr_sum >= NUM_REQ_W) begin
            ptr_sum = '0;
        end
        ptr_next = ptr_sum[IDX_W-1:0];
    end

    // Mux out the winner's address, direction and write data.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_write = bus.req_write[i];
            end
        end
    end

    // Accept pulse in the same cycle as the IDLE decision.
    always_comb begin
        req_ready_c = '0;
        if (!rst && state == IDLE && win_found) begin
            req_ready_c[winner] = 1'b1;
        end
    end

    // One-hot response strobe for the latched owner.
    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
    end

    // Transfer sequencer with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            timer        <= '0;
            rdata_r      <= '0;
            err_r        <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            hbusreq_q    <= 1'b0;
            haddr_q      <= '0;
            haddr_ctrl_q <= 1'b0;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= REQ;
                        owner     <= winner;
                        haddr_q   <= sel_addr;
                        hwrite_q  <= sel_write;
                        hwdata_q  <= sel_wdata;
                        hbusreq_q <= 1'b1;
                        timer     <= '0;
                        if (PRIO_MODE == 0) begin
                            rr_ptr <= ptr_next;
                        end
                    end
                end

                REQ: begin
                    if (bus.hgrant) begin
                        state        <= ADDR;
                        haddr_ctrl_q <= 1'b1;
                        timer        <= '0;
                    end else if (timer == TIMEOUT_CNT) begin
                        state       <= RESP;
                        hbusreq_q   <= 1'b0;
                        rsp_valid_q <= owner_onehot;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                ADDR: begin
                    state        <= DATA;
                    haddr_ctrl_q <= 1'b0;
                    hbusreq_q    <= 1'b0;
                    timer        <= '0;
                end

                DATA: begin
                    err_r <= err_r | bus.hresp_s2m;
                    if (bus.hready_s2m) begin
                        rdata_r <= bus.hdata_s2m;
                    end
                    // Response fields are built from this cycle's slave
                    // inputs as well, so a last-cycle hresp/hready still
                    // lands in the response.
                    if (!bus.hgrant) begin
                        state       <= RESP;
                        rsp_valid_q <= owner_onehot;
                        rsp_err_q   <= err_r | bus.hresp_s2m;
                        if (hwrite_q) begin
                            rsp_rdata_q <= '0;
                        end else if (bus.hready_s2m) begin
                            rsp_rdata_q <= bus.hdata_s2m;
                        end else begin
                            rsp_rdata_q <= rdata_r;
                        end
                        timer <= '0;
                    end else if (timer == TIMEOUT_CNT) begin
                        state       <= RESP;
                        rsp_valid_q <= owner_onehot;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                RESP: begin
                    state       <= IDLE;
                    rsp_valid_q <= '0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    err_r       <= 1'b0;
                    rdata_r     <= '0;
                    haddr_q     <= '0;
                    hwdata_q    <= '0;
                    hwrite_q    <= 1'b0;
                    timer       <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.hbusreq    = hbusreq_q;
    assign bus.haddr      = haddr_q;
    assign bus.haddr_ctrl = haddr_ctrl_q;
    assign bus.hwrite     = hwrite_q;
    assign bus.hwdata     = hwdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter. A round-robin instance and a
// fixed-priority instance (both TIMEOUT=8) receive identical stimulus.
module tb_ahb_master_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    ahb_master_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_fp ();

    assign bus_fp.req_valid  = bus_rr.req_valid;
    assign bus_fp.req_write  = bus_rr.req_write;
    assign bus_fp.req_addr   = bus_rr.req_addr;
    assign bus_fp.req_wdata  = bus_rr.req_wdata;
    assign bus_fp.hgrant     = bus_rr.hgrant;
    assign bus_fp.hready_s2m = bus_rr.hready_s2m;
    assign bus_fp.hresp_s2m  = bus_rr.hresp_s2m;
    assign bus_fp.hdata_s2m  = bus_rr.hdata_s2m;

    ahb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(8)
    ) dut_rr (
        .clk(clk),
        .rst(rst),
        .bus(bus_rr)
    );

    ahb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(8)
    ) dut_fp (
        .clk(clk),
        .rst(rst),
        .bus(bus_fp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Runs one transfer from the REQ cycle through the IDLE that follows.
    // Entered at the IDLE cycle where the command was accepted; returns
    // 1 time unit into the next IDLE cycle.
    task automatic serve(
        input int unsigned gdly,     input logic [1:0]  rv_after,
        input logic [63:0] wd_after, input logic [31:0] rd,
        input logic        er,
        input logic [1:0]  own_rr,   input logic [31:0] addr_rr,
        input logic [1:0]  own_fp,   input logic [31:0] addr_fp,
        input logic        wr,       input logic [31:0] wd,
        input logic [31:0] exp_rd,   input logic        exp_er
    );
        step();
        bus_rr.req_valid = rv_after;
        bus_rr.req_wdata = wd_after;
        bus_rr.hgrant    = 1'b0;
        for (int unsigned i = 0; i < gdly; i++) begin
            #1;
            check("req_wait_hbusreq", bus_rr.hbusreq, 1'b1);
            step();
        end
        bus_rr.hgrant = 1'b1;
        #1;
        check("req_hbusreq", bus_rr.hbusreq, 1'b1);
        check("req_ready_busy", bus_rr.req_ready, 2'b00);
        check("req_ctrl_low", bus_rr.haddr_ctrl, 1'b0);
        step();
        #1;
        check("addr_ctrl", bus_rr.haddr_ctrl, 1'b1);
        check("addr_hbusreq", bus_rr.hbusreq, 1'b1);
        check("addr_haddr", bus_rr.haddr, addr_rr);
        check("addr_haddr_fp", bus_fp.haddr, addr_fp);
        step();
        bus_rr.hgrant     = 1'b0;
        bus_rr.hready_s2m = 1'b1;
        bus_rr.hdata_s2m  = rd;
        bus_rr.hresp_s2m  = er;
        #1;
        check("data_ctrl", bus_rr.haddr_ctrl, 1'b0);
        check("data_hbusreq", bus_rr.hbusreq, 1'b0);
        check("data_haddr", bus_rr.haddr, addr_rr);
        check("data_hwrite", bus_rr.hwrite, wr);
        check("data_hwdata", bus_rr.hwdata, wd);
        step();
        bus_rr.hready_s2m = 1'b0;
        bus_rr.hdata_s2m  = '0;
        bus_rr.hresp_s2m  = 1'b0;
        #1;
        check("resp_valid", bus_rr.rsp_valid, own_rr);
        check("resp_rdata", bus_rr.rsp_rdata, exp_rd);
        check("resp_err", bus_rr.rsp_err, exp_er);
        check("resp_valid_fp", bus_fp.rsp_valid, own_fp);
        step();
        #1;
        check("idle_rsp_valid", bus_rr.rsp_valid, 2'b00);
        check("idle_haddr", bus_rr.haddr, 32'h0);
        check("idle_hwdata", bus_rr.hwdata, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0]  exp_own;
        logic [31:0] exp_addr;

        rst               = 1'b1;
        bus_rr.req_valid  = '0;
        bus_rr.req_write  = '0;
        bus_rr.req_addr   = '0;
        bus_rr.req_wdata  = '0;
        bus_rr.hgrant     = 1'b0;
        bus_rr.hready_s2m = 1'b0;
        bus_rr.hresp_s2m  = 1'b0;
        bus_rr.hdata_s2m  = '0;

        // reset state
        step();
        step();
        #1;
        check("rst_rsp_valid", bus_rr.rsp_valid, 2'b00);
        check("rst_hbusreq", bus_rr.hbusreq, 1'b0);
        check("rst_haddr", bus_rr.haddr, 32'h0);
        check("rst_ctrl", bus_rr.haddr_ctrl, 1'b0);
        check("rst_req_ready", bus_rr.req_ready, 2'b00);
        check("rst_rsp_err", bus_rr.rsp_err, 1'b0);
        rst = 1'b0;
        step();
        #1;
        check("idle_no_rsp", bus_rr.rsp_valid, 2'b00);

        // single read by requester 0, grant one cycle after hbusreq
        bus_rr.req_valid = 2'b01;
        bus_rr.req_addr  = {32'h0, 32'h0000_1000};
        #1;
        check("t1_ready", bus_rr.req_ready, 2'b01);
        check("t1_ready_fp", bus_fp.req_ready, 2'b01);
        serve(1, 2'b00, 64'h0, 32'hDEAD_BEEF, 1'b0,
              2'b01, 32'h0000_1000, 2'b01, 32'h0000_1000,
              1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // write by requester 1; wdata changes after acceptance, read data ignored
        bus_rr.req_valid = 2'b10;
        bus_rr.req_write = 2'b10;
        bus_rr.req_addr  = {32'h0000_2004, 32'h0};
        bus_rr.req_wdata = {32'h1234_5678, 32'h0};
        #1;
        check("t3_ready", bus_rr.req_ready, 2'b10);
        check("t3_ready_fp", bus_fp.req_ready, 2'b10);
        serve(0, 2'b00, {32'hBADB_AD00, 32'h0}, 32'hFFFF_FFFF, 1'b0,
              2'b10, 32'h0000_2004, 2'b10, 32'h0000_2004,
              1'b1, 32'h1234_5678, 32'h0, 1'b0);

        // both requesters held: RR alternates 0,1,0,1; fixed stays on 0
        bus_rr.req_valid = 2'b11;
        bus_rr.req_write = 2'b00;
        bus_rr.req_addr  = {32'h0000_0200, 32'h0000_0100};
        bus_rr.req_wdata = '0;
        #1;
        for (int unsigned i = 0; i < 4; i++) begin
            exp_own  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            check("t2_ready_rr", bus_rr.req_ready, exp_own);
            check("t2_ready_fp", bus_fp.req_ready, 2'b01);
            serve(0, 2'b11, 64'h0, 32'hA000_0000 + i, 1'b0,
                  exp_own, exp_addr, 2'b01, 32'h0000_0100,
                  1'b0, 32'h0, 32'hA000_0000 + i, 1'b0);
        end
        bus_rr.req_valid = 2'b00;

        // slave error in the completion cycle of a read
        bus_rr.req_valid = 2'b01;
        bus_rr.req_addr  = {32'h0, 32'h0000_3000};
        #1;
        check("t4_ready", bus_rr.req_ready, 2'b01);
        serve(0, 2'b00, 64'h0, 32'h55AA_0011, 1'b1,
              2'b01, 32'h0000_3000, 2'b01, 32'h0000_3000,
              1'b0, 32'h0, 32'h55AA_0011, 1'b1);

        // no grant: abort 9 cycles after REQ entry
        bus_rr.req_valid = 2'b01;
        bus_rr.req_addr  = {32'h0, 32'h0000_4000};
        #1;
        check("t5_ready", bus_rr.req_ready, 2'b01);
        step();
        bus_rr.req_valid = 2'b00;
        for (int unsigned i = 0; i < 9; i++) begin
            #1;
            check("t5_wait_rsp", bus_rr.rsp_valid, 2'b00);
            check("t5_wait_hbusreq", bus_rr.hbusreq, 1'b1);
            step();
        end
        #1;
        check("t5_rsp_valid", bus_rr.rsp_valid, 2'b01);
        check("t5_rsp_err", bus_rr.rsp_err, 1'b1);
        check("t5_rsp_rdata", bus_rr.rsp_rdata, 32'h0);
        check("t5_hbusreq", bus_rr.hbusreq, 1'b0);
        check("t5_rsp_valid_fp", bus_fp.rsp_valid, 2'b01);
        step();
        #1;
        check("t5_idle", bus_rr.rsp_valid, 2'b00);

        // reset during DATA of a write by requester 0
        bus_rr.req_valid = 2'b01;
        bus_rr.req_write = 2'b01;
        bus_rr.req_addr  = {32'h0, 32'h0000_5000};
        bus_rr.req_wdata = {32'h0, 32'hCAFE_0001};
        #1;
        check("t6_ready", bus_rr.req_ready, 2'b01);
        step();
        bus_rr.req_valid = 2'b00;
        bus_rr.hgrant    = 1'b1;
        step();
        step();
        #1;
        check("t6_data_haddr", bus_rr.haddr, 32'h0000_5000);
        check("t6_data_hwrite", bus_rr.hwrite, 1'b1);
        check("t6_data_hwdata", bus_rr.hwdata, 32'hCAFE_0001);
        rst               = 1'b1;
        bus_rr.hgrant     = 1'b0;
        bus_rr.hready_s2m = 1'b1;
        bus_rr.hdata_s2m  = 32'h0000_0077;
        step();
        #1;
        check("t6_rsp_valid", bus_rr.rsp_valid, 2'b00);
        check("t6_rsp_rdata", bus_rr.rsp_rdata, 32'h0);
        check("t6_rsp_err", bus_rr.rsp_err, 1'b0);
        check("t6_hbusreq", bus_rr.hbusreq, 1'b0);
        check("t6_haddr", bus_rr.haddr, 32'h0);
        check("t6_ctrl", bus_rr.haddr_ctrl, 1'b0);
        check("t6_hwrite", bus_rr.hwrite, 1'b0);
        check("t6_hwdata", bus_rr.hwdata, 32'h0);
        check("t6_rsp_valid_fp", bus_fp.rsp_valid, 2'b00);
        rst               = 1'b0;
        bus_rr.hready_s2m = 1'b0;
        bus_rr.hdata_s2m  = '0;
        step();
        #1;
        check("t6_no_late_rsp", bus_rr.rsp_valid, 2'b00);

        // pointer back at 0 after reset: RR picks 0 with both valid
        bus_rr.req_valid = 2'b11;
        bus_rr.req_write = 2'b00;
        bus_rr.req_addr  = {32'h0000_6000, 32'h0000_5000};
        bus_rr.req_wdata = '0;
        #1;
        check("t6_ptr_reset", bus_rr.req_ready, 2'b01);
        check("t6_ptr_reset_fp", bus_fp.req_ready, 2'b01);
        serve(0, 2'b00, 64'h0, 32'h0BAD_F00D, 1'b0,
              2'b01, 32'h0000_5000, 2'b01, 32'h0000_5000,
              1'b0, 32'h0, 32'h0BAD_F00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
